// File: rtl/jbus_demux_pkg.sv
// Shared encodings, widths and state type for the J bus demultiplexer.
package jbus_demux_pkg;

  localparam int unsigned J_W    = 16;
  localparam int unsigned P_W    = 19;
  localparam int unsigned P_LO_W = 16;
  localparam int unsigned P_HI_W = 3;
  localparam int unsigned SDRA_W = 14;
  localparam int unsigned SDPA_W = 12;
  localparam int unsigned CNT_W  = 4;

  // Phase select values; also used as the event bus identifier.
  localparam logic [1:0] PH_PLO  = 2'b00;
  localparam logic [1:0] PH_PHI  = 2'b01;
  localparam logic [1:0] PH_SDRA = 2'b10;
  localparam logic [1:0] PH_SDPA = 2'b11;

  localparam int unsigned PEND_P    = 0;
  localparam int unsigned PEND_SDRA = 1;
  localparam int unsigned PEND_SDPA = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PHASE  = 2'b01,
    ST_COMMIT = 2'b10
  } state_e;

endpackage

// File: rtl/jbus_sync.sv
// Parameterised multi-bit flip-flop synchroniser chain.
module jbus_sync #(
  parameter int unsigned W      = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/jbus_demux.sv
// Scans the multiplexed J bus, rebuilds P/SDRA/SDPA addresses, filters them
// across two scans and reports committed changes on a valid/ready event port.
module jbus_demux import jbus_demux_pkg::*; #(
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [J_W-1:0]    j,
  output logic [1:0]        js,
  output logic [P_W-1:0]    prg_addr,
  output logic [SDRA_W-1:0] sdra,
  output logic [SDPA_W-1:0] sdpa,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_bus,
  output logic [P_W-1:0]    evt_addr,
  output logic              scan_done
);

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  logic [J_W-1:0] j_sync;

  jbus_sync #(.W(J_W), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (j),
    .q     (j_sync)
  );

  state_e            state_q, state_d;
  logic [1:0]        js_q, js_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [P_W-1:0]    cand_p_q, cand_p_d, prev_p_q, prev_p_d;
  logic [SDRA_W-1:0] cand_sdra_q, cand_sdra_d, prev_sdra_q, prev_sdra_d;
  logic [SDPA_W-1:0] cand_sdpa_q, cand_sdpa_d, prev_sdpa_q, prev_sdpa_d;
  logic              prev_vld_q, prev_vld_d;
  logic [P_W-1:0]    prg_addr_q, prg_addr_d;
  logic [SDRA_W-1:0] sdra_q, sdra_d;
  logic [SDPA_W-1:0] sdpa_q, sdpa_d;
  logic [2:0]        pend_q, pend_d, pend_set, pend_clr;
  logic              evt_valid_q, evt_valid_d;
  logic [1:0]        evt_bus_q, evt_bus_d;
  logic [P_W-1:0]    evt_addr_q, evt_addr_d;
  logic              scan_done_q, scan_done_d;
  logic              commit;

  // Scan sequencer: settle per phase, sample on the last settle cycle.
  always_comb begin
    state_d     = state_q;
    js_d        = js_q;
    cnt_d       = cnt_q;
    cand_p_d    = cand_p_q;
    cand_sdra_d = cand_sdra_q;
    cand_sdpa_d = cand_sdpa_q;
    scan_done_d = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        js_d  = PH_PLO;
        cnt_d = '0;
        if (en) state_d = ST_PHASE;
      end
      ST_PHASE: begin
        if (cnt_q == SETTLE_CNT) begin
          cnt_d = '0;
          case (js_q)
            PH_PLO:  cand_p_d[P_LO_W-1:0]   = j_sync[P_LO_W-1:0];
            PH_PHI:  cand_p_d[P_W-1:P_LO_W] = j_sync[P_HI_W-1:0];
            PH_SDRA: cand_sdra_d            = j_sync[SDRA_W-1:0];
            default: cand_sdpa_d            = j_sync[SDPA_W-1:0];
          endcase
          if (js_q == PH_SDPA) begin
            state_d     = ST_COMMIT;
            scan_done_d = 1'b1;
          end else begin
            js_d = js_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        js_d    = PH_PLO;
        cnt_d   = '0;
        state_d = en ? ST_PHASE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Two-scan stability filter; a bus only flags when its output really changes.
  always_comb begin
    prg_addr_d  = prg_addr_q;
    sdra_d      = sdra_q;
    sdpa_d      = sdpa_q;
    prev_p_d    = prev_p_q;
    prev_sdra_d = prev_sdra_q;
    prev_sdpa_d = prev_sdpa_q;
    prev_vld_d  = prev_vld_q;
    pend_set    = '0;
    if (commit) begin
      if (prev_vld_q && (prev_p_q == cand_p_q) && (cand_p_q != prg_addr_q)) begin
        prg_addr_d       = cand_p_q;
        pend_set[PEND_P] = 1'b1;
      end
      if (prev_vld_q && (prev_sdra_q == cand_sdra_q) && (cand_sdra_q != sdra_q)) begin
        sdra_d              = cand_sdra_q;
        pend_set[PEND_SDRA] = 1'b1;
      end
      if (prev_vld_q && (prev_sdpa_q == cand_sdpa_q) && (cand_sdpa_q != sdpa_q)) begin
        sdpa_d              = cand_sdpa_q;
        pend_set[PEND_SDPA] = 1'b1;
      end
      prev_p_d    = cand_p_q;
      prev_sdra_d = cand_sdra_q;
      prev_sdpa_d = cand_sdpa_q;
      prev_vld_d  = 1'b1;
    end
  end

  // Event selection: set beats clear; presented address follows the live register.
  always_comb begin
    pend_clr = '0;
    if (evt_valid_q && evt_ready) begin
      case (evt_bus_q)
        PH_PLO:  pend_clr[PEND_P]    = 1'b1;
        PH_SDRA: pend_clr[PEND_SDRA] = 1'b1;
        PH_SDPA: pend_clr[PEND_SDPA] = 1'b1;
        default: pend_clr            = '0;
      endcase
    end
    pend_d      = (pend_q & ~pend_clr) | pend_set;
    evt_valid_d = |pend_d;
    evt_bus_d   = PH_PLO;
    evt_addr_d  = '0;
    if (pend_d[PEND_P]) begin
      evt_bus_d  = PH_PLO;
      evt_addr_d = prg_addr_d;
    end else if (pend_d[PEND_SDRA]) begin
      evt_bus_d  = PH_SDRA;
      evt_addr_d = P_W'(sdra_d);
    end else if (pend_d[PEND_SDPA]) begin
      evt_bus_d  = PH_SDPA;
      evt_addr_d = P_W'(sdpa_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      js_q        <= PH_PLO;
      cnt_q       <= '0;
      cand_p_q    <= '0;
      cand_sdra_q <= '0;
      cand_sdpa_q <= '0;
      prev_p_q    <= '0;
      prev_sdra_q <= '0;
      prev_sdpa_q <= '0;
      prev_vld_q  <= 1'b0;
      prg_addr_q  <= '0;
      sdra_q      <= '0;
      sdpa_q      <= '0;
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_bus_q   <= PH_PLO;
      evt_addr_q  <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      js_q        <= js_d;
      cnt_q       <= cnt_d;
      cand_p_q    <= cand_p_d;
      cand_sdra_q <= cand_sdra_d;
      cand_sdpa_q <= cand_sdpa_d;
      prev_p_q    <= prev_p_d;
      prev_sdra_q <= prev_sdra_d;
      prev_sdpa_q <= prev_sdpa_d;
      prev_vld_q  <= prev_vld_d;
      prg_addr_q  <= prg_addr_d;
      sdra_q      <= sdra_d;
      sdpa_q      <= sdpa_d;
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_bus_q   <= evt_bus_d;
      evt_addr_q  <= evt_addr_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign js        = js_q;
  assign prg_addr  = prg_addr_q;
  assign sdra      = sdra_q;
  assign sdpa      = sdpa_q;
  assign evt_valid = evt_valid_q;
  assign evt_bus   = evt_bus_q;
  assign evt_addr  = evt_addr_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_jbus_demux.sv
// Directed bench for jbus_demux with a behavioural address multiplexer.
module tb_jbus_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] j;
  logic [1:0]  js;
  logic [18:0] prg_addr;
  logic [13:0] sdra;
  logic [11:0] sdpa;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_bus;
  logic [18:0] evt_addr;
  logic        scan_done;

  logic [18:0] a_val;
  logic [13:0] sdra_val;
  logic [11:0] sdpa_val;
  logic        junk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [1:0]  ev_bus  [$];
  logic [18:0] ev_addr [$];
  int          ev_cyc  [$];

  jbus_demux dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .j         (j),
    .js        (js),
    .prg_addr  (prg_addr),
    .sdra      (sdra),
    .sdpa      (sdpa),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_bus   (evt_bus),
    .evt_addr  (evt_addr),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Address multiplexer model; junk drives 1s on the unused upper bits.
  always_comb begin
    case (js)
      2'b00:   j = a_val[15:0];
      2'b01:   j = junk ? (16'hFFF8 | {13'd0, a_val[18:16]}) : {13'd0, a_val[18:16]};
      2'b10:   j = junk ? {2'b11, sdra_val} : {2'b00, sdra_val};
      default: j = junk ? {4'hF, sdpa_val} : {4'h0, sdpa_val};
    endcase
  end

  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      ev_bus.push_back(evt_bus);
      ev_addr.push_back(evt_addr);
      ev_cyc.push_back(cyc);
    end
  end

  task automatic clear_events();
    ev_bus.delete();
    ev_addr.delete();
    ev_cyc.delete();
  endtask

  task automatic wait_scan(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_done !== 1'b1 && n < 200);
    if (scan_done !== 1'b1) begin
      $display("FAIL scan_timeout scan_done=%b after %0d cycles, want 1", scan_done, n);
      $fatal(1, "scan_done never arrived");
    end
  endtask

  task automatic wait_js(input logic [1:0] want);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (js !== want && n < 200);
    if (js !== want) begin
      $display("FAIL js_timeout js=%b want %b", js, want);
      $fatal(1, "js phase never reached");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; evt_ready = 1'b1; junk = 1'b0;
    a_val = 19'h51234; sdra_val = 14'h2ABC; sdpa_val = 12'h0F0;
    repeat (3) @(negedge clk);
    checks++; if (js !== 2'b00) $display("FAIL rst_js got %b want 00", js); else passed++;
    checks++; if (prg_addr !== 19'h0) $display("FAIL rst_prg got %h want 0", prg_addr); else passed++;
    checks++; if (sdra !== 14'h0) $display("FAIL rst_sdra got %h want 0", sdra); else passed++;
    checks++; if (sdpa !== 12'h0) $display("FAIL rst_sdpa got %h want 0", sdpa); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL rst_evt_valid got %b want 0", evt_valid); else passed++;
    checks++; if (evt_bus !== 2'b00) $display("FAIL rst_evt_bus got %b want 00", evt_bus); else passed++;
    checks++; if (evt_addr !== 19'h0) $display("FAIL rst_evt_addr got %h want 0", evt_addr); else passed++;
    checks++; if (scan_done !== 1'b0) $display("FAIL rst_scan_done got %b want 0", scan_done); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_static();
    int n;
    clear_events();
    @(negedge clk);
    en = 1'b1;
    wait_scan(n);
    checks++; if (n != 21) $display("FAIL static_scan_len got %0d want 21", n); else passed++;
    @(negedge clk);
    checks++; if (evt_valid !== 1'b0) $display("FAIL static_first_scan_evt got %b want 0", evt_valid); else passed++;
    checks++; if (prg_addr !== 19'h0) $display("FAIL static_first_scan_prg got %h want 0", prg_addr); else passed++;
    wait_scan(n);
    @(negedge clk);
    checks++; if (prg_addr !== 19'h51234) $display("FAIL static_prg got %h want 51234", prg_addr); else passed++;
    checks++; if (sdra !== 14'h2ABC) $display("FAIL static_sdra got %h want 2abc", sdra); else passed++;
    checks++; if (sdpa !== 12'h0F0) $display("FAIL static_sdpa got %h want 0f0", sdpa); else passed++;
    repeat (4) @(negedge clk);
    checks++; if (ev_bus.size() != 3) $display("FAIL static_ev_count got %0d want 3", ev_bus.size()); else passed++;
    checks++; if ({ev_bus[0], ev_addr[0]} !== {2'b00, 19'h51234})
      $display("FAIL static_ev0 got %b/%h want 00/51234", ev_bus[0], ev_addr[0]); else passed++;
    checks++; if ({ev_bus[1], ev_addr[1]} !== {2'b10, 19'h02ABC})
      $display("FAIL static_ev1 got %b/%h want 10/02abc", ev_bus[1], ev_addr[1]); else passed++;
    checks++; if ({ev_bus[2], ev_addr[2]} !== {2'b11, 19'h000F0})
      $display("FAIL static_ev2 got %b/%h want 11/000f0", ev_bus[2], ev_addr[2]); else passed++;
    checks++; if ((ev_cyc[1] != ev_cyc[0] + 1) || (ev_cyc[2] != ev_cyc[0] + 2))
      $display("FAIL static_ev_spacing got %0d,%0d,%0d want consecutive", ev_cyc[0], ev_cyc[1], ev_cyc[2]); else passed++;
  endtask

  task automatic test_tear();
    int n;
    int torn;
    wait_scan(n);
    a_val = 19'h0FFFF;
    clear_events();
    wait_scan(n);
    wait_scan(n);
    @(negedge clk);
    checks++; if (prg_addr !== 19'h0FFFF) $display("FAIL tear_base got %h want 0ffff", prg_addr); else passed++;
    wait_js(2'b01);
    a_val = 19'h10000;
    wait_scan(n);
    @(negedge clk);
    checks++; if (prg_addr !== 19'h0FFFF) $display("FAIL tear_scan_n got %h want 0ffff", prg_addr); else passed++;
    wait_scan(n);
    @(negedge clk);
    checks++; if (prg_addr !== 19'h0FFFF) $display("FAIL tear_scan_n1 got %h want 0ffff", prg_addr); else passed++;
    wait_scan(n);
    @(negedge clk);
    checks++; if (prg_addr !== 19'h10000) $display("FAIL tear_commit got %h want 10000", prg_addr); else passed++;
    repeat (2) @(negedge clk);
    torn = 0;
    foreach (ev_addr[i]) if (ev_addr[i] === 19'h1FFFF) torn++;
    checks++; if (torn != 0) $display("FAIL tear_torn_event got %0d torn events want 0", torn); else passed++;
    checks++; if (ev_bus.size() != 2) $display("FAIL tear_ev_count got %0d want 2", ev_bus.size()); else passed++;
    checks++; if ({ev_bus[1], ev_addr[1]} !== {2'b00, 19'h10000})
      $display("FAIL tear_ev_last got %b/%h want 00/10000", ev_bus[1], ev_addr[1]); else passed++;
  endtask

  task automatic test_backpressure();
    int n;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    wait_scan(n);
    sdra_val = 14'h0001;
    clear_events();
    wait_scan(n);
    wait_scan(n);
    @(negedge clk);
    checks++; if (sdra !== 14'h0001) $display("FAIL bp_sdra1 got %h want 0001", sdra); else passed++;
    checks++; if ({evt_valid, evt_bus, evt_addr} !== {1'b1, 2'b10, 19'h00001})
      $display("FAIL bp_evt1 got %b/%b/%h want 1/10/00001", evt_valid, evt_bus, evt_addr); else passed++;
    sdra_val = 14'h0002;
    wait_scan(n);
    wait_scan(n);
    @(negedge clk);
    checks++; if (sdra !== 14'h0002) $display("FAIL bp_sdra2 got %h want 0002", sdra); else passed++;
    checks++; if ({evt_valid, evt_bus, evt_addr} !== {1'b1, 2'b10, 19'h00002})
      $display("FAIL bp_coalesce got %b/%b/%h want 1/10/00002", evt_valid, evt_bus, evt_addr); else passed++;
    @(posedge clk); #1;
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ev_bus.size() != 1) $display("FAIL bp_ev_count got %0d want 1", ev_bus.size()); else passed++;
    checks++; if ({ev_bus[0], ev_addr[0]} !== {2'b10, 19'h00002})
      $display("FAIL bp_ev got %b/%h want 10/00002", ev_bus[0], ev_addr[0]); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", evt_valid); else passed++;
  endtask

  task automatic test_undefined_bits();
    int n;
    wait_scan(n);
    junk = 1'b1;
    a_val = 19'h31234;
    clear_events();
    wait_scan(n);
    wait_scan(n);
    @(negedge clk);
    checks++; if (prg_addr !== 19'h31234) $display("FAIL junk_prg got %h want 31234", prg_addr); else passed++;
    checks++; if (sdra !== 14'h0002) $display("FAIL junk_sdra got %h want 0002", sdra); else passed++;
    checks++; if (sdpa !== 12'h0F0) $display("FAIL junk_sdpa got %h want 0f0", sdpa); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (ev_bus.size() != 1) $display("FAIL junk_ev_count got %0d want 1", ev_bus.size()); else passed++;
    checks++; if ({ev_bus[0], ev_addr[0]} !== {2'b00, 19'h31234})
      $display("FAIL junk_ev got %b/%h want 00/31234", ev_bus[0], ev_addr[0]); else passed++;
  endtask

  task automatic test_en_drop();
    int n;
    int extra_done;
    int js_bad;
    wait_js(2'b10);
    en = 1'b0;
    wait_scan(n);
    checks++; if (n > 15) $display("FAIL endrop_finish got %0d cycles want <=15", n); else passed++;
    @(negedge clk);
    checks++; if (js !== 2'b00) $display("FAIL endrop_js got %b want 00", js); else passed++;
    extra_done = 0;
    js_bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (scan_done !== 1'b0) extra_done++;
      if (js !== 2'b00) js_bad++;
    end
    checks++; if (extra_done != 0) $display("FAIL endrop_idle_scans got %0d want 0", extra_done); else passed++;
    checks++; if (js_bad != 0) $display("FAIL endrop_idle_js got %0d non-zero cycles want 0", js_bad); else passed++;
  endtask

  task automatic test_async_reset();
    int n;
    a_val = 19'h45678;
    @(negedge clk);
    en = 1'b1;
    wait_js(2'b10);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (prg_addr !== 19'h0) $display("FAIL arst_prg got %h want 0", prg_addr); else passed++;
    checks++; if (sdra !== 14'h0) $display("FAIL arst_sdra got %h want 0", sdra); else passed++;
    checks++; if (sdpa !== 12'h0) $display("FAIL arst_sdpa got %h want 0", sdpa); else passed++;
    checks++; if (js !== 2'b00) $display("FAIL arst_js got %b want 00", js); else passed++;
    checks++; if ({evt_valid, evt_bus, evt_addr, scan_done} !== 23'h0)
      $display("FAIL arst_evt got %b/%b/%h/%b want 0/00/0/0", evt_valid, evt_bus, evt_addr, scan_done); else passed++;
    @(negedge clk);
    reset = 1'b0;
    wait_scan(n);
    checks++; if (n != 21) $display("FAIL arst_scan_len got %0d want 21", n); else passed++;
    @(negedge clk);
    checks++; if ({evt_valid, prg_addr} !== {1'b0, 19'h0})
      $display("FAIL arst_first_scan got %b/%h want 0/0", evt_valid, prg_addr); else passed++;
    wait_scan(n);
    @(negedge clk);
    checks++; if (prg_addr !== 19'h45678) $display("FAIL arst_prg_commit got %h want 45678", prg_addr); else passed++;
    checks++; if ({evt_valid, evt_bus, evt_addr} !== {1'b1, 2'b00, 19'h45678})
      $display("FAIL arst_evt_first got %b/%b/%h want 1/00/45678", evt_valid, evt_bus, evt_addr); else passed++;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_static();
    test_tear();
    test_backpressure();
    test_undefined_bits();
    test_en_drop();
    test_async_reset();
    repeat (30) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jbus_demux.md
Name: jbus_demux

Overview:
- Cartridge-side receiver for the multiplexed J bus driven by the program-board address multiplexer.
- Drives the 2-bit select js and samples j in each of four phases:
  - 00: P-ROM address A[15:0]
  - 01: A[18:16] in j[2:0]
  - 10: SDRA[13:0]
  - 11: SDPA[11:0]
- Rebuilds the three address buses and filters them for stability.
- Reports each committed change through a valid/ready event port to the flash/SDRAM read front end.

Parameters:
- SETTLE, 4: cycles from a js change to the sample of synchronised j; covers mux propagation plus the 2-FF synchroniser; legal range 3..15.
- SYNC_STAGES, 2: synchroniser depth on j; must be less than SETTLE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  scanning enable
- j  in  16  multiplexed bus from the address multiplexer (asynchronous to clk)
- js  out  2  phase select driven to the multiplexer
- prg_addr  out  19  committed P-ROM address
- sdra  out  14  committed SDRA
- sdpa  out  12  committed SDPA
- evt_valid  out  1  change event pending
- evt_ready  in  1  consumer accepts event
- evt_bus  out  2  00 = P, 10 = SDRA, 11 = SDPA (same encoding as js)
- evt_addr  out  19  committed value of evt_bus, zero-extended
- scan_done  out  1  one-cycle pulse per completed scan

Behaviour:
- Reset values, all outputs and state: js=00, prg_addr/sdra/sdpa=0, evt_valid=0, evt_bus=00, evt_addr=0, scan_done=0, FSM=IDLE, previous-scan candidates marked invalid.
- Reset asserted mid-scan clears all of the above immediately; no partial commit.
- j passes through a SYNC_STAGES flip-flop synchroniser before any use.
- FSM states: IDLE, PHASE, COMMIT.
  - IDLE to PHASE when en=1: js=00, phase counter cleared.
  - PHASE holds js for SETTLE+1 cycles and samples synchronised j on the last cycle.
    - js=00: capture j[15:0] into cand_p[15:0].
    - js=01: capture j[2:0] into cand_p[18:16]; j[15:3] is undefined and ignored.
    - js=10: capture j[13:0] into cand_sdra.
    - js=11: capture j[11:0] into cand_sdpa.
    - After a sample, js advances 00, 01, 10, 11 on the next cycle; after phase 11 go to COMMIT.
  - COMMIT lasts one cycle and pulses scan_done. Then:
    - en=1: return to PHASE with js=00.
    - en=0: go to IDLE with js=00.
  - Deasserting en mid-scan completes the current scan and its commit.
- Scan length is 4*(SETTLE+1)+1 cycles, which is 21 at the default.
- Stability filter, applied per bus at COMMIT:
  - The bus commits only if the valid previous-scan candidate equals the current candidate.
  - The bus updates and raises its pending flag only if the committed value differs from the output register.
  - The current candidate then becomes the previous candidate and is marked valid.
  - The first scan after reset never commits.
  - A stable value of 0 after reset produces no event.
- P address tearing: A[15:0] and A[18:16] are sampled in different phases. Both halves must match across two scans, so a torn value never commits.
- Event port:
  - pending[2:0] holds one flag per bus; evt_valid = OR of the flags.
  - Priority order: P, then SDRA, then SDPA.
  - evt_addr is the live output register of the selected bus, so repeated changes coalesce to the latest value.
  - evt_valid && evt_ready clears the selected flag.
  - If a commit sets the same flag in the same cycle, set wins.
  - evt_bus and evt_addr stay constant while evt_valid=1 and evt_ready=0, except for a same-bus coalesced update or a higher-priority bus becoming pending.
- Width rules: sdra and sdpa zero-extend to 19 bits on evt_addr; upper unused j bits never reach any output.

Decomposition:
- Shared package holds:
  - phase/bus encodings: PH_PLO=00, PH_PHI=01, PH_SDRA=10, PH_SDPA=11;
  - address widths 19, 14 and 12;
  - FSM state typedef.
- One natural sub-module, jbus_sync: a parameterised multi-bit 2-FF synchroniser, reusable elsewhere.

Test Plan:
- Static bus, event acceptance: en=1 with A=0x5_1234, SDRA=0x2ABC, SDPA=0x0F0 held; evt_ready=1.
  - No commit at the first scan_done (cycle 21).
  - After the second scan: prg_addr=0x51234, sdra=0x2ABC, sdpa=0x0F0.
  - Events arrive in the order P, SDRA, SDPA on consecutive cycles.
- Tear rejection: A changes 0x0FFFF to 0x10000 during phase 01 of a scan.
  - No event carries a torn value such as 0x1FFFF.
  - Only 0x10000 commits, after two matching scans.
- Backpressure and coalescing: evt_ready=0 while SDRA goes 0x0001 then 0x0002, each stable for 2 scans.
  - evt_valid stays 1.
  - Raising evt_ready yields exactly one SDRA event with evt_addr=0x00002.
- Undefined bits: phase 01 drives j=0xFFF8|A[18:16] with A[18:16]=3.
  - prg_addr[18:16]=3 and no other bits are affected.
  - Phase 10 with j[15:14]=11 leaves sdra unaffected.
- en drop mid-scan: clear en during phase 10.
  - Scan completes and scan_done pulses.
  - FSM goes to IDLE with js=00 and no further samples.
- Async reset mid-scan, asserted between clock edges:
  - All outputs return to reset values without waiting for a clock edge.
  - After release the first event needs two full scans.
